// File: rtl/arbitro_comparador_if.sv
// Request/result bundle between the two requesters and the shared comparator arbiter.
// The master side drives requests and operands; the slave side returns grants and results.
interface arbitro_comparador_if #(
    parameter int WIDTH  = 6,
    parameter int CWIDTH = 8
);
    logic              req0;
    logic [WIDTH-1:0]  a0;
    logic [WIDTH-1:0]  b0;
    logic              req1;
    logic [WIDTH-1:0]  a1;
    logic [WIDTH-1:0]  b1;
    logic              gnt0;
    logic              gnt1;
    logic              busy;
    logic              valid;
    logic              diferente;
    logic              id;
    logic [CWIDTH-1:0] cont_dif;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, valid, diferente, id, cont_dif
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, valid, diferente, id, cont_dif
    );
endinterface

// File: rtl/arbitro_comparador.sv
// Round-robin arbiter sharing one WIDTH-bit inequality comparator between two requesters,
// with a registered tagged result pulse and a saturating count of "different" results.
module arbitro_comparador_xor #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             dif_o
);
    assign dif_o = |(a_i ^ b_i);
endmodule

module arbitro_comparador #(
    parameter int WIDTH  = 6,
    parameter int CWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    arbitro_comparador_if.slave   bus
);
    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        COMPARA   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    estado_t           estado_q;
    logic [WIDTH-1:0]  reg_a_q;
    logic [WIDTH-1:0]  reg_b_q;
    logic              ultimo_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              valid_q;
    logic              dif_q;
    logic              id_q;
    logic [CWIDTH-1:0] cont_q;

    logic              hay_req;
    logic              ganador_d;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic              dif_d;
    logic [CWIDTH-1:0] cont_d;

    arbitro_comparador_xor #(.WIDTH(WIDTH)) u_xor (
        .a_i   (reg_a_q),
        .b_i   (reg_b_q),
        .dif_o (dif_d)
    );

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        hay_req   = bus.req0 | bus.req1;
        ganador_d = 1'b0;
        if (bus.req0 && bus.req1) ganador_d = ~ultimo_q;
        else if (bus.req1)        ganador_d = 1'b1;
        a_sel = ganador_d ? bus.a1 : bus.a0;
        b_sel = ganador_d ? bus.b1 : bus.b0;
    end

    always_comb begin
        cont_d = cont_q;
        if (dif_d && (cont_q != {CWIDTH{1'b1}})) cont_d = cont_q + CWIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            ultimo_q <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid_q  <= 1'b0;
            dif_q    <= 1'b0;
            id_q     <= 1'b0;
            cont_q   <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    valid_q <= 1'b0;
                    if (hay_req) begin
                        reg_a_q  <= a_sel;
                        reg_b_q  <= b_sel;
                        id_q     <= ganador_d;
                        ultimo_q <= ganador_d;
                        gnt0_q   <= ~ganador_d;
                        gnt1_q   <= ganador_d;
                        estado_q <= COMPARA;
                    end
                end
                COMPARA: begin
                    dif_q    <= dif_d;
                    valid_q  <= 1'b1;
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    cont_q   <= cont_d;
                    estado_q <= RESULTADO;
                end
                RESULTADO: begin
                    // Requests are deliberately ignored here, giving one comparison per 3 cycles.
                    valid_q  <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = (estado_q != OCIOSO);
    assign bus.valid     = valid_q;
    assign bus.diferente = dif_q;
    assign bus.id        = id_q;
    assign bus.cont_dif  = cont_q;
endmodule
